// File: rtl/bicubic_phase_gen.sv
// bicubic_phase_gen: per-pixel source coordinate and phase generator for a bicubic scaler
// Ports: clk/rst_n (sync active-low); start launches a frame using step_x/step_y (Q8.8)
// and dst_width/dst_height; out_valid/out_ready handshake carries x_int/xBlend, y_int/yBlend
// with sol/eol/sof/eof markers; busy is high while running, done pulses at frame end.
// Define BICUBIC_CENTER_ALIGN_EN for pixel-centre initial phase; default is top-left.
module bicubic_phase_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] step_x,
    input  logic [15:0] step_y,
    input  logic [11:0] dst_width,
    input  logic [11:0] dst_height,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [8:0]  xBlend,
    output logic [8:0]  yBlend,
    output logic [11:0] x_int,
    output logic [11:0] y_int,
    output logic        sol,
    output logic        eol,
    output logic        sof,
    output logic        eof,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [15:0] step_x_q, step_x_d, step_y_q, step_y_d;
    logic [11:0] w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
    logic signed [20:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic signed [20:0] init_x, init_xr, init_y, sum_x, sum_y;
    logic xfer, last_col, last_row;
`ifdef BICUBIC_CENTER_ALIGN_EN
    function automatic logic signed [20:0] phase0(input logic [15:0] s);
        return $signed({5'd0, s >> 1}) - 21'sd128;
    endfunction
    assign init_x  = phase0(step_x);
    assign init_xr = phase0(step_x_q);
    assign init_y  = phase0(step_y);
`else
    assign init_x  = '0;
    assign init_xr = '0;
    assign init_y  = '0;
`endif
    assign sum_x    = acc_x_q + $signed({5'd0, step_x_q});
    assign sum_y    = acc_y_q + $signed({5'd0, step_y_q});
    assign xfer     = state_q == RUN && out_ready;
    assign last_col = col_q == w_q - 12'd1;
    assign last_row = row_q == h_q - 12'd1;
    always_comb begin
        state_d  = state_q;
        step_x_d = step_x_q;
        step_y_d = step_y_q;
        w_d      = w_q;
        h_d      = h_q;
        col_d    = col_q;
        row_d    = row_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        if (state_q == IDLE && start) begin
            step_x_d = step_x;
            step_y_d = step_y;
            w_d      = dst_width;
            h_d      = dst_height;
            col_d    = '0;
            row_d    = '0;
            acc_x_d  = init_x;
            acc_y_d  = init_y;
            state_d  = (dst_width == 12'd0 || dst_height == 12'd0) ? DONE : RUN;
        end else if (xfer && last_col) begin
            col_d   = '0;
            acc_x_d = init_xr;
            state_d = last_row ? DONE : RUN;
            row_d   = last_row ? row_q : row_q + 12'd1;
            // a non-negative accumulator wraps modulo 2^20 instead of turning negative
            acc_y_d = last_row ? acc_y_q : {acc_y_q[20] & sum_y[20], sum_y[19:0]};
        end else if (xfer) begin
            col_d   = col_q + 12'd1;
            acc_x_d = {acc_x_q[20] & sum_x[20], sum_x[19:0]};
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_x_q <= '0;
            step_y_q <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
        end else begin
            state_q  <= state_d;
            step_x_q <= step_x_d;
            step_y_q <= step_y_d;
            w_q      <= w_d;
            h_q      <= h_d;
            col_q    <= col_d;
            row_q    <= row_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
        end
    end
    assign out_valid = state_q == RUN;
    assign busy      = out_valid;
    assign done      = state_q == DONE;
    assign sol       = out_valid && col_q == 12'd0;
    assign eol       = out_valid && last_col;
    assign sof       = sol && row_q == 12'd0;
    assign eof       = eol && last_row;
    // negative accumulators (centre alignment at small steps) clamp to the first source pixel
    assign x_int     = acc_x_q[20] ? 12'd0 : acc_x_q[19:8];
    assign y_int     = acc_y_q[20] ? 12'd0 : acc_y_q[19:8];
    assign xBlend    = {1'b0, acc_x_q[20] ? 8'd0 : acc_x_q[7:0]};
    assign yBlend    = {1'b0, acc_y_q[20] ? 8'd0 : acc_y_q[7:0]};
endmodule

// File: doc/bicubic_phase_gen.md
BICUBIC_PHASE_GEN -- requirements
Module: bicubic_phase_gen

Interface
REQ-001 SHALL have no parameters; all widths below are fixed.
REQ-002 clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  one-cycle frame start request, honoured only in IDLE.
REQ-005 step_x, step_y  in  16 each  source increment per destination pixel/line, unsigned Q8.8 (0x0100 = 1.0).
REQ-006 dst_width, dst_height  in  12 each  destination frame size in pixels/lines.
REQ-007 out_valid  out  1  coordinate word valid.
REQ-008 out_ready  in  1  downstream weight pipeline accepts word.
REQ-009 xBlend, yBlend  out  9 each  fractional phase {1'b0,frac[7:0]}, 0..255 against coeffOne = 256.
REQ-010 x_int, y_int  out  12 each  integer source column/row.
REQ-011 sol, eol, sof, eof  out  1 each  start/end of line, start/end of frame, qualified by out_valid.
REQ-012 busy  out  1  high in RUN; done  out  1  one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 IDLE->RUN on start; step_x, step_y, dst_width, dst_height SHALL be latched that cycle; later input changes SHALL not affect the frame.
REQ-015 If latched dst_width or dst_height is 0, IDLE->DONE directly; no out_valid asserted.
REQ-016 out_valid SHALL be 1 from the first RUN cycle, presenting pixel (0,0) one cycle after start.
REQ-017 Transfer occurs when out_valid & out_ready; while out_ready=0 all outputs SHALL hold stable.
REQ-018 X accumulator: signed 21-bit Q12.8; += step_x per transfer; reloaded to initial phase after eol transfer.
REQ-019 Y accumulator: same format; += step_y on eol transfer only.
REQ-020 x_int/xBlend SHALL be acc[19:8]/acc[7:0]; negative accumulator SHALL output x_int=0, xBlend=0 (same for y).
REQ-021 Accumulator overflow beyond 4095.996 SHALL wrap modulo 2^20; software avoids it.
REQ-022 sol at column 0, eol at column dst_width-1, sof at (0,0), eof at (dst_width-1,dst_height-1).
REQ-023 Transfer of eof word: RUN->DONE; out_valid SHALL drop the next cycle.
REQ-024 DONE SHALL assert done for exactly one cycle, then enter IDLE.
REQ-025 start in RUN or DONE SHALL be ignored.
REQ-026 Single-cycle throughput: one transfer per clock when out_ready held high.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE; out_valid, busy, done, sol, eol, sof, eof = 0; xBlend, yBlend, x_int, y_int = 0; accumulators and counters = 0.
REQ-028 Reset mid-frame SHALL abandon the frame without asserting done; start is accepted the first cycle after rst_n returns high.

Configuration
REQ-029 Macro BICUBIC_CENTER_ALIGN_EN defined: initial phase = (step>>1) - 0x80 (signed) per axis, pixel-centre alignment.
REQ-030 Macro undefined: initial phase = 0 per axis (top-left alignment); no extra logic compiled.

Verification
REQ-031 step 0x0100/0x0100, 4x2, ready=1 -> 8 words, x_int 0,1,2,3 per line, y_int 0 then 1, all blends 0, done pulse one cycle after eof transfer.
REQ-032 step_x 0x0080, width 4, height 1, macro off -> (x_int,xBlend) = (0,0),(0,128),(1,0),(1,128); sol on first, eol/eof on last.
REQ-033 Same as REQ-032 with BICUBIC_CENTER_ALIGN_EN -> (0,0),(0,64),(0,192),(1,64).
REQ-034 out_ready low 3 cycles mid-line -> outputs unchanged during stall, sequence resumes without skip or repeat.
REQ-035 rst_n low for 1 cycle at pixel 5 of a 4x4 frame -> all outputs 0, no done; new start produces full 16-word frame from (0,0).
REQ-036 dst_width 0 with start -> no out_valid, done pulses one cycle after DONE entry; start during RUN -> ignored, frame count unchanged.
